// File: rtl/mem_rd_framer_pkg.sv
// Shared types and constants for the memory read-stream framer.
package mem_rd_framer_pkg;

  // Framer states; HDR is only reached when the header option is built in
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  // Upper half of the frame header word
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  // Ceiling log2 for sizing counters and pointers at elaboration time
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_rd_framer_fifo.sv
// Falling-edge synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module mem_rd_framer_fifo
  import mem_rd_framer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; only control state is reset
  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are qualified by the pointers so need no reset
  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_rd_framer.sv
// Frames the memory controller read stream into fixed-length packets:
// FRAME_LEN payload words followed by a checksum word (plain sum, truncated).
// Optional build macro MEM_RD_FRAMER_HDR_EN prefixes every frame with a
// header word {HDR_MAGIC, frame_cnt}; sof then marks the header.
// The memory side cannot be stalled: a word arriving into a full FIFO with
// no simultaneous pop is dropped and the sticky overflow flag is raised.
module mem_rd_framer
  import mem_rd_framer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int WCW = clog2(FRAME_LEN);

`ifdef MEM_RD_FRAMER_HDR_EN
  localparam state_t START_ST = HDR;
`else
  localparam state_t START_ST = PAYLOAD;
`endif

  state_t           state;
  logic [WCW-1:0]   word_cnt;
  logic [WIDTH-1:0] csum;
  logic [WIDTH-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             xfer;
  logic             pop;
  logic             last_word;

  assign xfer      = out_valid && out_ready;
  assign pop       = (state == PAYLOAD) && xfer;
  assign last_word = (word_cnt == WCW'(FRAME_LEN - 1));

  mem_rd_framer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output word selection; everything is driven from flops so it holds
  // steady while the downstream stalls
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state)
`ifdef MEM_RD_FRAMER_HDR_EN
      HDR: begin
        out_valid = 1'b1;
        out_data  = WIDTH'({HDR_MAGIC, frame_cnt});
        out_sof   = 1'b1;
      end
`endif
      PAYLOAD: begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : head;
`ifdef MEM_RD_FRAMER_HDR_EN
        out_sof   = 1'b0;
`else
        out_sof   = !fifo_empty && (word_cnt == '0);
`endif
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_eof   = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame sequencer: walks header/payload/checksum and accumulates the sum
  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      csum      <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          csum     <= '0;
          word_cnt <= '0;
          state    <= START_ST;
        end
        HDR: begin
          if (xfer) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (xfer) begin
            csum     <= csum + head;
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            frame_cnt <= frame_cnt + 16'd1;
            csum      <= '0;
            word_cnt  <= '0;
            state     <= START_ST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag: a full FIFO with no pop this cycle cannot take the word
  always_ff @(negedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (in_valid && fifo_full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_mem_rd_framer.sv
// Scoreboard bench for mem_rd_framer. The driver pushes the expected frame
// words into a queue as it issues input words; an independent monitor pops
// and compares on every output transfer and checks stall stability.
module tb_mem_rd_framer;

  localparam int WIDTH     = 32;
  localparam int FRAME_LEN = 8;
  localparam int DEPTH     = 16;
`ifdef MEM_RD_FRAMER_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             overflow;
  logic [15:0]      frame_cnt;

  mem_rd_framer #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             sof;
    logic             eof;
  } beat_t;

  beat_t            exp_q[$];
  int               tests = 0;
  int               fails = 0;
  int               m_pos;
  logic [WIDTH-1:0] m_sum;
  logic [15:0]      m_frames;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [WIDTH-1:0] d, input logic sof, input logic eof);
    beat_t b;
    b.d = d; b.sof = sof; b.eof = eof;
    return b;
  endfunction

  // Reference model: a frame is [header] + FRAME_LEN words + their sum
  task automatic model_reset();
    exp_q.delete();
    m_pos = 0;
    m_sum = '0;
    m_frames = 16'd0;
    if (HDR_ON) exp_q.push_back(mk(WIDTH'({16'hA5A5, m_frames}), 1'b1, 1'b0));
  endtask

  task automatic model_word(input logic [WIDTH-1:0] w);
    exp_q.push_back(mk(w, (m_pos == 0) && !HDR_ON, 1'b0));
    m_sum = m_sum + w;
    m_pos++;
    if (m_pos == FRAME_LEN) begin
      exp_q.push_back(mk(m_sum, 1'b0, 1'b1));
      m_frames = m_frames + 16'd1;
      m_pos = 0;
      m_sum = '0;
      if (HDR_ON) exp_q.push_back(mk(WIDTH'({16'hA5A5, m_frames}), 1'b1, 1'b0));
    end
  endtask

  function automatic bit drained();
    return (exp_q.size() == 0) || (HDR_ON && exp_q.size() == 1 && m_pos == 0);
  endfunction

  // Monitor: samples on the rising edge, half a cycle from the DUT's edge
  initial begin
    bit    hold_prev;
    beat_t hold_b;
    beat_t e;
    hold_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (hold_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, hold_b.d);
          check("hold_sof", out_sof, hold_b.sof);
          check("hold_eof", out_eof, hold_b.eof);
        end
        if (out_valid === 1'b1) begin
          check("sof_eof_excl", out_sof & out_eof, 1'b0);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_xfer: got data 0x%0h sof %0b eof %0b, expected no word",
                       out_data, out_sof, out_eof);
            end else begin
              e = exp_q.pop_front();
              check("xfer_data", out_data, e.d);
              check("xfer_sof", out_sof, e.sof);
              check("xfer_eof", out_eof, e.eof);
            end
          end
        end
        hold_prev = (out_valid === 1'b1) && !out_ready;
        hold_b    = mk(out_data, out_sof, out_eof);
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // One cycle of stimulus, applied just after the DUT's falling edge
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic drain(input bit toggle);
    for (int k = 0; k < 400; k++) begin
      if (drained()) break;
      cycle(1'b0, '0, toggle ? (k % 2 == 1) : 1'b1);
    end
    if (!drained()) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sof", out_sof, 1'b0);
    check("rst_out_eof", out_eof, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic             v;
    int               n;
    int               pushed;

    reset_dut();

    // Basic frame: 1..8 back to back, downstream always ready
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b1);
      model_word(WIDTH'(i));
    end
    drain(1'b0);
    check("basic_frame_cnt", frame_cnt, 16'd1);

    // Backpressure: ready toggles every cycle
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, WIDTH'(i), (i % 2 == 1));
      model_word(WIDTH'(i));
    end
    drain(1'b1);
    check("bp_frame_cnt", frame_cnt, 16'd2);

    // Checksum wrap
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, '1, 1'b1);
      model_word('1);
    end
    drain(1'b0);
    check("wrap_frame_cnt", frame_cnt, 16'd3);

    // Overflow: 20 pushes into a stalled 16-entry FIFO
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0);
      if (i == 17) check("ovf_after_16", overflow, 1'b0);
      if (i == 18) check("ovf_after_17", overflow, 1'b1);
      if (i <= DEPTH) model_word(WIDTH'(i));
    end
    cycle(1'b0, '0, 1'b0);
    check("ovf_after_20", overflow, 1'b1);
    drain(1'b0);
    check("ovf_frame_cnt", frame_cnt, 16'd5);
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-frame: 5 words queued, 3 taken, then reset
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, WIDTH'(32'h100 + i), 1'b0);
      model_word(WIDTH'(32'h100 + i));
    end
    for (int i = 0; i < (HDR_ON ? 4 : 3); i++) cycle(1'b0, '0, 1'b1);
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, WIDTH'(32'h10), 1'b1);
      model_word(WIDTH'(32'h10));
    end
    drain(1'b0);
    check("rstmid_frame_cnt", frame_cnt, 16'd1);
    check("rstmid_overflow", overflow, 1'b0);

    // Full FIFO with push and pop in the same cycle
    reset_dut();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0);
      model_word(WIDTH'(i));
    end
    if (HDR_ON) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, WIDTH'(DEPTH + 1), 1'b1);
    model_word(WIDTH'(DEPTH + 1));
    cycle(1'b0, '0, 1'b1);
    check("fullpop_overflow", overflow, 1'b0);
    drain(1'b0);
    check("fullpop_frame_cnt", frame_cnt, 16'd2);
    check("fullpop_overflow_end", overflow, 1'b0);

    // Randomized bursts, each small enough that the FIFO cannot overflow
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, DEPTH);
      pushed = 0;
      for (int c = 0; c < 400 && pushed < n; c++) begin
        v = ($urandom % 4) != 0;
        d = ($urandom % 5 == 0) ? '1 : WIDTH'($urandom);
        cycle(v, d, 1'($urandom % 2));
        if (v) begin
          model_word(d);
          pushed++;
        end
      end
      cycle(1'b0, '0, 1'b1);
      drain(1'b0);
      check("rand_frame_cnt", frame_cnt, m_frames);
      check("rand_overflow", overflow, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
